systolic_drain: RTL
===================

// Module: systolic_drain
// PURPOSE
//  Result-side reader for the row-stationary INT8 systolic array. After a tile
//  finishes, it waits for the skewed PE pipelines to settle. It then snapshots
//  the row-major INT32 accumulator bus and pulses the array's synchronous clear,
//  so the next tile can start. Finally it serialises the snapshot as a
//  valid/ready word stream toward the output buffer / DMA.
// PARAMETERS
//  N_ROWS     2           array rows; must match the array instance
//  N_COLS     2           array columns; must match the array instance
//  FLUSH_CYC  N_COLS+1    settle cycles between start and snapshot (0 allowed)
// PORTS
//  clk        in   1                 clock
//  rst_n      in   1                 async active-low reset
//  start      in   1                 tile compute complete; sampled only in IDLE
//  c_in_flat  in   N_ROWS*N_COLS*32  array accumulators, word k at [k*32+:32], k=r*N_COLS+c
//  arr_clr    out  1                 one-cycle clear pulse to the array's clr input
//  busy       out  1                 high in every state except IDLE
//  m_valid    out  1                 output word valid
//  m_ready    in   1                 downstream accept
//  m_data     out  32                output word (signed INT32)
//  m_idx      out  IW                word index k; IW=max(1,$clog2(N_ROWS*N_COLS))
//  m_last     out  1                 high with m_valid on word N_ROWS*N_COLS-1
//  done       out  1                 one-cycle pulse after the final handshake
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; counters 0. Snapshot buffer is not reset.
//  - FSM states: IDLE -> FLUSH -> SNAP -> STREAM -> IDLE.
//  - IDLE: start=1 -> FLUSH, with the settle counter loaded to FLUSH_CYC.
//    If FLUSH_CYC=0, IDLE goes directly to SNAP.
//  - FLUSH: remains in FLUSH for exactly FLUSH_CYC cycles, then -> SNAP.
//  - SNAP (1 cycle): arr_clr=1. The clock edge ending SNAP captures all of
//    c_in_flat into the buffer. The array clears on that same edge, so the
//    buffer holds the pre-clear values. SNAP -> STREAM with m_idx=0.
//  - Latency: with start high in cycle 0, SNAP occurs in cycle FLUSH_CYC+1.
//    m_valid first rises in cycle FLUSH_CYC+2.
//  - STREAM: m_valid=1, m_data=buf[m_idx], m_last=(m_idx==N_ROWS*N_COLS-1).
//    A handshake is m_valid & m_ready and advances m_idx by 1.
//    While m_valid=1 and m_ready=0, m_data, m_idx and m_last hold stable.
//    m_valid never drops without a handshake.
//  - A handshake on the last word -> IDLE. In the next cycle done=1, busy=0,
//    and start is accepted in that same cycle (back-to-back tiles).
//  - start outside IDLE is ignored; no queueing.
//  - N_ROWS*N_COLS=1: a single beat, with m_last=1 on it.
//  - m_idx counts 0..N_ROWS*N_COLS-1 and never wraps within a tile.
//  - Reset mid-operation: immediate return to IDLE; no arr_clr or done pulse.
//    The partial stream is abandoned.
//  - arr_clr is asserted only in SNAP and is independent of m_ready.
// CONFIGURATION
//  SYSTOLIC_DRAIN_RELU_EN
//   - Defined: m_data = (buf[k] < 0) ? 0 : buf[k] (signed compare). Applied on
//     the output mux only; the buffer holds raw values.
//   - Undefined: m_data = buf[k], raw two's complement.
//   - Handshake timing is identical in both builds.
// TESTING
//  T1 2x2, FLUSH_CYC=3, c_in={40,-7,300,-1} (k=0..3), m_ready=1, start in cycle 0
//     -> arr_clr in cycle 4 only; m_valid cycles 5-8 with m_data 40,-7,300,-1;
//     m_last in cycle 8; done in cycle 9.
//  T2 Same data, m_ready toggling 1,0,0,1,...
//     -> data/idx stable during stalls; exactly 4 handshakes; no lost/duplicate word.
//  T3 Change c_in_flat to all 0x7FFFFFFF from cycle 5 onward
//     -> output still shows the cycle-4 snapshot.
//  T4 start pulsed during STREAM -> ignored; then start in the done cycle
//     -> second tile's arr_clr at done_cycle+FLUSH_CYC+1.
//  T5 rst_n low mid-STREAM at word 2 -> m_valid, busy, done and arr_clr go to 0
//     asynchronously; the next start produces a full 4-word stream from k=0.
//  T6 SYSTOLIC_DRAIN_RELU_EN defined, data as T1 -> m_data 40,0,300,0.
//     1x1 with FLUSH_CYC=0 -> SNAP in cycle 1, a single beat in cycle 2 with m_last=1.

Source files
------------

// File: rtl/systolic_drain_if.sv
// Output word stream from systolic_drain toward the output buffer / DMA.
// m_idx width IW must equal max(1, $clog2(N_ROWS*N_COLS)) of the attached drain.
interface systolic_drain_if #(
    parameter int unsigned IW = 1
) ();
    logic          m_valid;
    logic          m_ready;
    logic [31:0]   m_data;
    logic [IW-1:0] m_idx;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_idx,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_idx,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/systolic_drain.sv
// Result-side reader for the systolic array: settle, snapshot + clear, then stream words.
// Optional macro SYSTOLIC_DRAIN_RELU_EN clamps negative output words to zero.
module systolic_drain #(
    parameter int unsigned N_ROWS    = 2,
    parameter int unsigned N_COLS    = 2,
    parameter int unsigned FLUSH_CYC = N_COLS + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_ROWS*N_COLS*32-1:0]  c_in_flat,
    output logic                         arr_clr,
    output logic                         busy,
    output logic                         done,
    systolic_drain_if.master             m_if
);

    localparam int unsigned DW = 32;
    localparam int unsigned NW = N_ROWS * N_COLS;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned CW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_SNAP,
        S_STREAM
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic             arr_clr_q, arr_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NW*DW-1:0] buf_q;
    logic             hs;
    logic [IW-1:0]    nxt_idx;
    int unsigned      nxt_k;

    // Output shaping lives on the mux only; the buffer always keeps raw values.
    function automatic logic [DW-1:0] shape(input logic [DW-1:0] w);
`ifdef SYSTOLIC_DRAIN_RELU_EN
        return w[DW-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    // Snapshot is taken on the same edge that clears the array.
    always_ff @(posedge clk) begin
        if (state_q == S_SNAP) begin
            buf_q <= c_in_flat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            arr_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            arr_clr_q <= arr_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        m_data_d  = m_data_q;
        hs        = m_valid_q & m_if.m_ready;
        nxt_idx   = idx_q + IW'(1);
        nxt_k     = m_last_q ? 32'd0 : 32'(nxt_idx);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = CW'(FLUSH_CYC);
                    state_d = (FLUSH_CYC == 0) ? S_SNAP : S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_SNAP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_SNAP: begin
                // Buffer is still loading, so word 0 comes straight from the bus.
                state_d  = S_STREAM;
                idx_d    = '0;
                m_data_d = shape(c_in_flat[DW-1:0]);
            end
            S_STREAM: begin
                if (hs) begin
                    if (m_last_q) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d    = nxt_idx;
                        m_data_d = shape(buf_q[nxt_k*DW +: DW]);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        arr_clr_d = (state_d == S_SNAP);
        busy_d    = (state_d != S_IDLE);
        m_valid_d = (state_d == S_STREAM);
        m_last_d  = (state_d == S_STREAM) && (idx_d == IW'(NW - 1));
        done_d    = (state_q == S_STREAM) && hs && m_last_q;
    end

    assign arr_clr     = arr_clr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_data  = m_data_q;
    assign m_if.m_idx   = idx_q;
    assign m_if.m_last  = m_last_q;

endmodule
